// File: rtl/abcd_stimulus_sequencer_if.sv
// -----------------------------------------------------------------------------
// abcd_stimulus_sequencer_if
//
// Bundle of the sequencer's user-facing signals. The clock and reset are kept
// outside the bundle as plain ports on the sequencer.
//
// Handshake: none of these signals handshake. key_step_n and sw_run are raw
// asynchronous levels; the sequencer synchronises them internally.
// new_vector is a one-cycle strobe that marks the first cycle a new index is
// presented. wrap is only ever high together with new_vector.
//
// Signals
//   key_step_n  raw pushbutton, active-low, bouncy
//   sw_run      raw slide switch, 1 = AUTO, 0 = MANUAL
//   A,B,C,D     index[3..0]
//   index       current combination number
//   new_vector  one-cycle strobe on each advance
//   wrap        one-cycle strobe when index goes 15 -> 0
//   auto_mode   1 while the FSM is in AUTO
//   dbg_state   raw FSM state register, for checkers
//
// Modports
//   master  the side that drives the button and switch (board or bench)
//   slave   the sequencer
// -----------------------------------------------------------------------------
interface abcd_stimulus_sequencer_if;
    logic       key_step_n;
    logic       sw_run;
    logic       A;
    logic       B;
    logic       C;
    logic       D;
    logic [3:0] index;
    logic       new_vector;
    logic       wrap;
    logic       auto_mode;
    logic [0:0] dbg_state;

    modport master (
        output key_step_n, sw_run,
        input  A, B, C, D, index, new_vector, wrap, auto_mode, dbg_state
    );

    modport slave (
        input  key_step_n, sw_run,
        output A, B, C, D, index, new_vector, wrap, auto_mode, dbg_state
    );
endinterface

// File: rtl/abcd_stimulus_sequencer.sv
// -----------------------------------------------------------------------------
// abcd_stimulus_sequencer
//
// Produces the four logic inputs A..D for the Task 2 logic block. Each of the
// 16 combinations can be applied in one of two ways:
//   - MANUAL mode: one debounced button press advances the index by one.
//   - AUTO mode: the index advances every RUN_PERIOD cycles.
//
// Parameters
//   DEBOUNCE_CYCLES  stable synchronised samples needed to accept a key change (>= 2)
//   RUN_PERIOD       cycles between advances in AUTO (>= 2)
//
// Ports
//   clock    system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      abcd_stimulus_sequencer_if.slave: button/switch in, vector out
// -----------------------------------------------------------------------------
module abcd_stimulus_sequencer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int RUN_PERIOD      = 25000000
) (
    input  logic                          clock,
    input  logic                          reset_n,
    abcd_stimulus_sequencer_if.slave      bus
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TK_W = (RUN_PERIOD > 2) ? $clog2(RUN_PERIOD) : 1;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TK_W-1:0] TK_LAST = TK_W'(RUN_PERIOD - 1);

    localparam logic [0:0] S_MANUAL = 1'b0;
    localparam logic [0:0] S_AUTO   = 1'b1;

    logic [1:0]      r_key_sync;
    logic [1:0]      r_run_sync;
    logic            r_key_db;
    logic            r_key_db_q;
    logic [DB_W-1:0] r_db_cnt;
    logic [TK_W-1:0] r_tick_cnt;
    logic [0:0]      r_state;
    logic [3:0]      r_index;
    logic            r_new_vector;
    logic            r_wrap;

    logic            w_key_s;
    logic            w_run_s;
    logic            w_press;
    logic            w_tick;
    logic            w_advance;

    assign w_key_s = r_key_sync[1];
    assign w_run_s = r_run_sync[1];

    // Two-flop synchronisers; the key idles released (1), the switch idles MANUAL (0).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_key_sync <= 2'b11;
            r_run_sync <= 2'b00;
        end else begin
            r_key_sync <= {r_key_sync[0], bus.key_step_n};
            r_run_sync <= {r_run_sync[0], bus.sw_run};
        end
    end

    // Debouncer: key_db only follows the synchronised key after DEBOUNCE_CYCLES
    // consecutive differing samples; any agreeing sample restarts the count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_key_db   <= 1'b1;
            r_key_db_q <= 1'b1;
            r_db_cnt   <= '0;
        end else begin
            r_key_db_q <= r_key_db;
            if (w_key_s == r_key_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_key_db <= w_key_s;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    // Press is the falling edge of the debounced level; releases are ignored.
    assign w_press = r_key_db_q & ~r_key_db;

    assign w_tick = (r_state == S_AUTO) && w_run_s && (r_tick_cnt == TK_LAST);

    // A press only counts in MANUAL. In AUTO a tick only counts while the
    // synchronised switch is still high, so a switch drop beats a coincident tick.
    assign w_advance = ((r_state == S_MANUAL) && w_press) || w_tick;

    // Mode FSM and AUTO tick counter. The counter restarts on every mode change.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_MANUAL;
            r_tick_cnt <= '0;
        end else begin
            case (r_state)
                S_MANUAL: begin
                    if (w_run_s) begin
                        r_state    <= S_AUTO;
                        r_tick_cnt <= '0;
                    end
                end
                S_AUTO: begin
                    if (!w_run_s) begin
                        r_state    <= S_MANUAL;
                        r_tick_cnt <= '0;
                    end else if (r_tick_cnt == TK_LAST) begin
                        r_tick_cnt <= '0;
                    end else begin
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_MANUAL;
                    r_tick_cnt <= '0;
                end
            endcase
        end
    end

    // Index register and its one-cycle strobes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_index      <= 4'd0;
            r_new_vector <= 1'b0;
            r_wrap       <= 1'b0;
        end else begin
            r_new_vector <= w_advance;
            r_wrap       <= w_advance && (r_index == 4'd15);
            if (w_advance) begin
                r_index <= r_index + 4'd1;
            end
        end
    end

    assign bus.A          = r_index[3];
    assign bus.B          = r_index[2];
    assign bus.C          = r_index[1];
    assign bus.D          = r_index[0];
    assign bus.index      = r_index;
    assign bus.new_vector = r_new_vector;
    assign bus.wrap       = r_wrap;
    assign bus.auto_mode  = (r_state == S_AUTO);
    assign bus.dbg_state  = r_state;

endmodule
